// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full adder, LSB first, one bit per clock.
// Optional signed-overflow output is enabled by defining SERIAL_ADD_OVF_EN.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             input_clk,
  input  logic             input_rst,
  input  logic             input_start,
  input  logic [WIDTH-1:0] input_a,
  input  logic [WIDTH-1:0] input_b,
  input  logic             input_cin,
  output logic             output_busy_o,
  output logic             output_done_o,
  output logic [WIDTH-1:0] output_sum_o,
  output logic             output_cout_o
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             output_ovf_o
`endif
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic [WIDTH-2:0]   res_sh;
  logic               carry;
  logic [CNT_W-1:0]   cnt;
  logic               fa_sum;
  logic               fa_cout;
  logic               last_bit;
  logic [WIDTH-1:0]   res_cat;

  full_adder u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));
  // New sum bit enters at the top; after WIDTH shifts the LSB has reached bit 0.
  assign res_cat  = {fa_sum, res_sh};

  always_ff @(posedge input_clk) begin
    if (input_rst) begin
      state         <= IDLE;
      a_sh          <= '0;
      b_sh          <= '0;
      res_sh        <= '0;
      carry         <= 1'b0;
      cnt           <= '0;
      output_busy_o <= 1'b0;
      output_done_o <= 1'b0;
      output_sum_o  <= '0;
      output_cout_o <= 1'b0;
    end else begin
      output_done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (input_start) begin
            a_sh          <= input_a;
            b_sh          <= input_b;
            carry         <= input_cin;
            cnt           <= '0;
            state         <= RUN;
            output_busy_o <= 1'b1;
          end
        end
        RUN: begin
          res_sh <= res_cat[WIDTH-1:1];
          carry  <= fa_cout;
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          cnt    <= cnt + 1'b1;
          if (last_bit) begin
            output_sum_o  <= res_cat;
            output_cout_o <= fa_cout;
            output_busy_o <= 1'b0;
            output_done_o <= 1'b1;
            state         <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state         <= IDLE;
          output_busy_o <= 1'b0;
        end
      endcase
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  // On the final bit the carry register holds the carry into the MSB.
  always_ff @(posedge input_clk) begin
    if (input_rst) begin
      output_ovf_o <= 1'b0;
    end else if (state == RUN && last_bit) begin
      output_ovf_o <= carry ^ fa_cout;
    end
  end
`else
  // Unsigned-only build: no overflow tracking.
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8) with an arithmetic reference model.
// Overflow checks are included when SERIAL_ADD_OVF_EN is defined.

module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         cin;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif

  int checks      = 0;
  int miscompares = 0;

  int     n = 0;
  int     k = 0;
  bit     have_op = 1'b0;
  bit     model_valid = 1'b0;
  logic [W-1:0] m_sum, p_sum;
  logic         m_cout, p_cout, m_ovf, p_ovf;
  logic         exp_busy, exp_done;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .input_clk     (clk),
    .input_rst     (rst),
    .input_start   (start),
    .input_a       (a),
    .input_b       (b),
    .input_cin     (cin),
    .output_busy_o (busy),
    .output_done_o (done),
    .output_sum_o  (sum),
    .output_cout_o (cout)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .output_ovf_o  (ovf)
`endif
  );

  always #5 clk = ~clk;

  // Returns {ovf, cout, sum} from plain integer arithmetic.
  function automatic logic [W+1:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
    longint full, sx, sy, ss;
    logic [W+1:0] r;
    full = longint'(x) + longint'(y) + longint'(c);
    sx = x[W-1] ? longint'(x) - (longint'(1) << W) : longint'(x);
    sy = y[W-1] ? longint'(y) - (longint'(1) << W) : longint'(y);
    ss = sx + sy + longint'(c);
    r[W-1:0] = full[W-1:0];
    r[W]     = full[W];
    r[W+1]   = (ss > (longint'(1) << (W - 1)) - 1) || (ss < -(longint'(1) << (W - 1)));
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s (edge %0d): got %0h, expected %0h", name, n, act, exp);
    end
  endtask

  // Reference timeline: accepted at edge k, busy after edges k..k+W-1, done after k+W.
  always @(posedge clk) begin
    n++;
    if (rst) begin
      have_op     = 1'b0;
      m_sum       = '0;
      m_cout      = 1'b0;
      m_ovf       = 1'b0;
      model_valid = 1'b1;
    end else begin
      if (have_op && n == k + W) begin
        m_sum  = p_sum;
        m_cout = p_cout;
        m_ovf  = p_ovf;
      end
      if (start && (!have_op || n >= k + W + 2)) begin
        have_op = 1'b1;
        k       = n;
        {p_ovf, p_cout, p_sum} = ref_add(a, b, cin);
      end
    end
    #1;
    if (model_valid) begin
      exp_busy = have_op && (n >= k) && (n < k + W);
      exp_done = have_op && (n == k + W);
      checkOutput("busy", busy, exp_busy);
      checkOutput("done", done, exp_done);
      checkOutput("sum",  sum,  m_sum);
      checkOutput("cout", cout, m_cout);
`ifdef SERIAL_ADD_OVF_EN
      checkOutput("ovf",  ovf,  m_ovf);
`endif
    end
  end

  task automatic applyStimulus(input logic s, input logic [W-1:0] aa, input logic [W-1:0] bb,
                               input logic c, input logic r);
    @(negedge clk);
    start = s;
    a     = aa;
    b     = bb;
    cin   = c;
    rst   = r;
  endtask

  task automatic waitDone(output int busy_cnt, output bit seen);
    busy_cnt = 0;
    seen     = 1'b0;
    for (int i = 0; i < 4 * W; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) busy_cnt++;
    end
    if (!seen) begin
      checks++;
      miscompares++;
      $display("[TB] FAIL done_timeout: got no done pulse, expected one within %0d cycles", 4 * W);
    end
  endtask

  task automatic runOp(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic c,
                       output int busy_cnt);
    bit seen;
    applyStimulus(1'b1, aa, bb, c, 1'b0);
    waitDone(busy_cnt, seen);
  endtask

  function automatic logic [W-1:0] pickOperand();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return {1'b0, {(W-1){1'b1}}};
      3: return {1'b1, {(W-1){1'b0}}};
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    int  bc;
    int  last_done;
    int  ncomp;
    int  done_cnt;
    bit  seen;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_sum",  sum,  0);
    checkOutput("rst_cout", cout, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);

    runOp(8'h5A, 8'h3C, 1'b0, bc);
    checkOutput("lit_5a3c_sum",  sum,  8'h96);
    checkOutput("lit_5a3c_cout", cout, 0);
    checkOutput("lit_5a3c_busy_cycles", bc, 8);

    runOp(8'hFF, 8'h01, 1'b0, bc);
    checkOutput("lit_ff01_sum",  sum,  8'h00);
    checkOutput("lit_ff01_cout", cout, 1);
    runOp(8'hFF, 8'hFF, 1'b1, bc);
    checkOutput("lit_ffff1_sum",  sum,  8'hFF);
    checkOutput("lit_ffff1_cout", cout, 1);

    // Starts during RUN and DONE must not disturb the 0x12+0x34 operation.
    applyStimulus(1'b1, 8'h12, 8'h34, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h12, 8'h34, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h12, 8'h34, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hAA, 8'hBB, 1'b1, 1'b0);
    waitDone(bc, seen);
    start = 1'b1; a = 8'h77; b = 8'h66; cin = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("ign_sum",  sum,  8'h46);
    checkOutput("ign_busy_after_done", busy, 0);
    @(negedge clk);
    checkOutput("ign_busy_idle", busy, 0);
    checkOutput("ign_sum_hold", sum, 8'h46);

    // Reset together with start on the 4th RUN edge aborts the operation.
    applyStimulus(1'b1, 8'h33, 8'h44, 1'b1, 1'b0);
    repeat (3) applyStimulus(1'b0, 8'h33, 8'h44, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h55, 8'h66, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h55, 8'h66, 1'b0, 1'b0);
    checkOutput("abort_sum",  sum,  0);
    checkOutput("abort_cout", cout, 0);
    checkOutput("abort_busy", busy, 0);
    done_cnt = 0;
    repeat (W + 2) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    checkOutput("abort_no_done", done_cnt, 0);
    runOp(8'h21, 8'h42, 1'b1, bc);
    checkOutput("after_abort_sum", sum, 8'h64);

    // Start held high: completions every WIDTH+2 cycles.
    last_done = -1;
    ncomp = 0;
    for (int i = 0; i < 46; i++) begin
      applyStimulus(1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'b0);
      if (done) begin
        if (last_done >= 0) checkOutput("b2b_period", i - last_done, W + 2);
        last_done = i;
        ncomp++;
      end
    end
    checkOutput("b2b_count_ge4", (ncomp >= 4), 1);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    repeat (W + 3) @(negedge clk);

`ifdef SERIAL_ADD_OVF_EN
    runOp(8'h7F, 8'h01, 1'b0, bc);
    checkOutput("ovf_7f01_sum", sum, 8'h80);
    checkOutput("ovf_7f01_ovf", ovf, 1);
    runOp(8'h80, 8'hFF, 1'b0, bc);
    checkOutput("ovf_80ff_sum",  sum,  8'h7F);
    checkOutput("ovf_80ff_cout", cout, 1);
    checkOutput("ovf_80ff_ovf",  ovf,  1);
    runOp(8'h10, 8'h20, 1'b0, bc);
    checkOutput("ovf_1020_ovf", ovf, 0);
`endif

    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 3) == 0), pickOperand(), pickOperand(),
                    1'($urandom), ($urandom_range(0, 60) == 0));
    end
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    repeat (W + 3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", checks, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
